// File: rtl/carry_select_subtractor_seq.sv
// Sequential carry-select subtractor: diff = a + ~b + 1, one N-bit block per cycle, LSB block first.
// Optional macro CARRY_SELECT_SUBTRACTOR_SATURATE_EN clamps diff to 0 when borrow=1.
module carry_select_subtractor_seq #(
  parameter int N      = 4,
  parameter int BLOCKS = 4,
  localparam int W     = N * BLOCKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // CALC  | one block per cycle, idx_q selects the block
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, nb_q, res_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     a_blk, nb_blk;
  logic [N:0]       sum0, sum1, sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both candidate sums are formed every cycle; the registered carry picks one.
  always_comb begin
    a_blk  = a_q[idx_q*N +: N];
    nb_blk = nb_q[idx_q*N +: N];
    sum0   = {1'b0, a_blk} + {1'b0, nb_blk};
    sum1   = sum0 + 1'b1;
    sel    = carry_q ? sum1 : sum0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      nb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            nb_q    <= ~b;
            res_q   <= '0;
            carry_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        CALC: begin
          res_q[idx_q*N +: N] <= sel[N-1:0];
          carry_q             <= sel[N];
          idx_q               <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign borrow    = out_valid & ~carry_q;

`ifdef CARRY_SELECT_SUBTRACTOR_SATURATE_EN
  assign diff = (out_valid && !borrow) ? res_q : '0;
`else
  assign diff = out_valid ? res_q : '0;
`endif

endmodule
